lsu_bus_router: RTL

- Parametrised successor to the LSU request router; sits between the LSQ and both the dcache and the Wishbone bus.
- Routes each LSQ request by address window: cacheable requests go to the dcache, MMIO requests go to Wishbone.
- Adds what the current router lacks:
  - a real bus FSM with registered bus outputs;
  - byte-lane shifting plus sign/zero extension of load data;
  - misalignment and timeout error reporting;
  - a one-entry bus response buffer arbitrated against dcache responses.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_load_align.sv | 30 +++
 rtl/lsu_bus_router.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: MMIO window, bus timeout, bus FSM states, access sizes.
package lsu_pkg;

   localparam logic [63:0] LSU_BUS_MAP_ADDR_LOWER = 64'h1000_0000;
   localparam logic [63:0] LSU_BUS_MAP_ADDR_UPPER = 64'h2000_0000;
   localparam int unsigned LSU_BUS_TIMEOUT        = 255;

   typedef enum logic [1:0] {
      BUS_IDLE = 2'd0,
      BUS_REQ  = 2'd1,
      BUS_RESP = 2'd2
   } bus_state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

endpackage

// File: rtl/lsu_load_align.sv
// Shifts read data down to byte lane 0 and sign/zero extends it to XLEN.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned DATA_LEN = 32,
   parameter int unsigned OFF_W    = 2
) (
   input  logic [DATA_LEN-1:0] data_i,
   input  logic [OFF_W-1:0]    off_i,
   input  logic [1:0]          size_i,
   input  logic                sign_i,
   output logic [XLEN-1:0]     data_o
);

   logic [XLEN-1:0] shifted;

   // Lane shift followed by extension from the access's top bit
   always_comb begin
      shifted = XLEN'(data_i) >> {off_i, 3'b000};
      data_o  = shifted;
      unique case (size_i)
         SIZE_B:  data_o = {{(XLEN-8){sign_i & shifted[7]}}, shifted[7:0]};
         SIZE_H:  data_o = {{(XLEN-16){sign_i & shifted[15]}}, shifted[15:0]};
         SIZE_W:  data_o = {{(XLEN-32){sign_i & shifted[31]}}, shifted[31:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_bus_router.sv
// Routes LSQ requests to the dcache or, inside the MMIO window, to Wishbone.
module lsu_bus_router
   import lsu_pkg::*;
#(
   parameter int unsigned VIRTUAL_ADDR_LEN   = 39,
   parameter int unsigned XLEN               = 64,
   parameter int unsigned LSU_LSQ_SIZE_WIDTH = 3,
   parameter int unsigned WB_DATA_LEN        = 32,
   parameter logic [63:0] BUS_MAP_ADDR_LOWER = LSU_BUS_MAP_ADDR_LOWER,
   parameter logic [63:0] BUS_MAP_ADDR_UPPER = LSU_BUS_MAP_ADDR_UPPER,
   parameter int unsigned BUS_TIMEOUT        = LSU_BUS_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          flush,
   input  logic                          lsq_req_valid_i,
   output logic                          lsq_req_ready_o,
   input  logic                          lsq_req_opcode_i,
   input  logic                          lsq_req_sign_i,
   input  logic [1:0]                    lsq_req_size_i,
   input  logic [VIRTUAL_ADDR_LEN-1:0]   lsq_req_addr_i,
   input  logic [XLEN-1:0]               lsq_req_data_i,
   input  logic [LSU_LSQ_SIZE_WIDTH-1:0] lsq_req_lsq_index_i,
   output logic                          lsq_resp_valid_o,
   input  logic                          lsq_resp_ready_i,
   output logic [LSU_LSQ_SIZE_WIDTH-1:0] lsq_resp_lsq_index_o,
   output logic [XLEN-1:0]               lsq_resp_data_o,
   output logic                          lsq_resp_err_o,
   output logic                          dcache_req_valid_o,
   input  logic                          dcache_req_ready_i,
   output logic                          dcache_req_opcode_o,
   output logic                          dcache_req_sign_o,
   output logic [1:0]                    dcache_req_size_o,
   output logic [VIRTUAL_ADDR_LEN-1:0]   dcache_req_addr_o,
   output logic [XLEN-1:0]               dcache_req_data_o,
   output logic [LSU_LSQ_SIZE_WIDTH-1:0] dcache_req_lsq_index_o,
   input  logic                          dcache_resp_valid_i,
   input  logic [LSU_LSQ_SIZE_WIDTH-1:0] dcache_resp_lsq_index_i,
   input  logic [XLEN-1:0]               dcache_resp_data_i,
   output logic                          dcache_resp_ready_o,
   output logic                          wb_cyc_o,
   output logic                          wb_stb_o,
   output logic                          wb_we_o,
   output logic [VIRTUAL_ADDR_LEN-1:0]   wb_adr_o,
   output logic [WB_DATA_LEN-1:0]        wb_dat_o,
   output logic [WB_DATA_LEN/8-1:0]      wb_sel_o,
   input  logic                          wb_ack_i,
   input  logic                          wb_err_i,
   input  logic [WB_DATA_LEN-1:0]        wb_dat_i
);

   localparam int unsigned WB_BYTES = WB_DATA_LEN / 8;
   localparam int unsigned OFF_W    = $clog2(WB_BYTES);
   localparam int unsigned CNT_W    = $clog2(BUS_TIMEOUT + 1);

   bus_state_e                    state_q, state_d;
   logic                          cyc_q, cyc_d;
   logic                          we_q, we_d;
   logic [VIRTUAL_ADDR_LEN-1:0]   adr_q, adr_d;
   logic [WB_DATA_LEN-1:0]        dat_q, dat_d;
   logic [WB_BYTES-1:0]           sel_q, sel_d;
   logic [OFF_W-1:0]              off_q, off_d;
   logic [1:0]                    size_q, size_d;
   logic                          sign_q, sign_d;
   logic [LSU_LSQ_SIZE_WIDTH-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [XLEN-1:0]               rdata_q, rdata_d;
   logic                          err_q, err_d;

   logic                          map_to_bus;
   logic                          bus_accept;
   logic                          misaligned;
   logic [OFF_W-1:0]              req_off;
   logic [3:0]                    size_bytes;
   logic [XLEN-1:0]               load_data;
   logic                          buf_valid;

   lsu_load_align #(
      .XLEN     (XLEN),
      .DATA_LEN (WB_DATA_LEN),
      .OFF_W    (OFF_W)
   ) u_load_align (
      .data_i (wb_dat_i),
      .off_i  (off_q),
      .size_i (size_q),
      .sign_i (sign_q),
      .data_o (load_data)
   );

   // Address decode, dcache pass-through and bus acceptance checks
   always_comb begin
      map_to_bus = (64'(lsq_req_addr_i) >= BUS_MAP_ADDR_LOWER) &&
                   (64'(lsq_req_addr_i) <  BUS_MAP_ADDR_UPPER);
      req_off    = lsq_req_addr_i[OFF_W-1:0];
      size_bytes = 4'd1 << lsq_req_size_i;
      misaligned = (32'(size_bytes) > WB_BYTES) ||
                   ((req_off & OFF_W'(size_bytes - 4'd1)) != '0);
      bus_accept = lsq_req_valid_i && map_to_bus && (state_q == BUS_IDLE) && !flush;

      dcache_req_valid_o     = lsq_req_valid_i && !map_to_bus;
      dcache_req_opcode_o    = lsq_req_opcode_i;
      dcache_req_sign_o      = lsq_req_sign_i;
      dcache_req_size_o      = lsq_req_size_i;
      dcache_req_addr_o      = lsq_req_addr_i;
      dcache_req_data_o      = lsq_req_data_i;
      dcache_req_lsq_index_o = lsq_req_lsq_index_i;
      lsq_req_ready_o        = map_to_bus ? ((state_q == BUS_IDLE) && !flush)
                                          : dcache_req_ready_i;
   end

   // State and bus/response registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= BUS_IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         off_q   <= off_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state and datapath capture; error beats ack, flush overrides all
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      off_d   = off_q;
      size_d  = size_q;
      sign_d  = sign_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         BUS_IDLE: begin
            if (bus_accept) begin
               idx_d  = lsq_req_lsq_index_i;
               size_d = lsq_req_size_i;
               sign_d = lsq_req_sign_i;
               off_d  = req_off;
               if (misaligned) begin
                  state_d = BUS_RESP;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = BUS_REQ;
                  cyc_d   = 1'b1;
                  we_d    = lsq_req_opcode_i;
                  adr_d   = {lsq_req_addr_i[VIRTUAL_ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}};
                  sel_d   = WB_BYTES'((9'd1 << size_bytes) - 9'd1) << req_off;
                  dat_d   = WB_DATA_LEN'(lsq_req_data_i) << {req_off, 3'b000};
                  cnt_d   = '0;
               end
            end
         end
         BUS_REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (wb_err_i || (cnt_q == CNT_W'(BUS_TIMEOUT))) begin
               state_d = BUS_RESP;
               cyc_d   = 1'b0;
               rdata_d = '0;
               err_d   = 1'b1;
            end else if (wb_ack_i) begin
               cyc_d   = 1'b0;
               state_d = we_q ? BUS_IDLE : BUS_RESP;
               rdata_d = load_data;
               err_d   = 1'b0;
            end
         end
         BUS_RESP: begin
            if (lsq_resp_ready_i) state_d = BUS_IDLE;
         end
         default: state_d = BUS_IDLE;
      endcase
      if (flush) begin
         state_d = BUS_IDLE;
         cyc_d   = 1'b0;
      end
   end

   // Registered bus outputs and response arbitration with buffer priority
   always_comb begin
      wb_cyc_o             = cyc_q;
      wb_stb_o             = cyc_q;
      wb_we_o              = we_q;
      wb_adr_o             = adr_q;
      wb_dat_o             = dat_q;
      wb_sel_o             = sel_q;
      buf_valid            = (state_q == BUS_RESP);
      lsq_resp_valid_o     = buf_valid || dcache_resp_valid_i;
      lsq_resp_lsq_index_o = buf_valid ? idx_q : dcache_resp_lsq_index_i;
      lsq_resp_data_o      = buf_valid ? rdata_q : dcache_resp_data_i;
      lsq_resp_err_o       = buf_valid && err_q;
      dcache_resp_ready_o  = lsq_resp_ready_i && !buf_valid;
   end

endmodule
